// File: rtl/axi_burst_master_pkg.sv
// Shared types and constants for the AXI3 burst master: FSM states, burst/response
// codes, status-error bit positions and the worst-response helper.
package axi_burst_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int ERR_DATA    = 0;
    localparam int ERR_LAST    = 1;
    localparam int ERR_ID      = 2;
    localparam int ERR_TIMEOUT = 3;

    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_pattern_gen.sv
// Combinational test pattern: the 32-bit word (seed + beat) replicated across the bus.
module axi_burst_pattern_gen #(
    parameter int AXI_DWIDTH = 64
) (
    input  logic [31:0]           seed,
    input  logic [3:0]            beat,
    output logic [AXI_DWIDTH-1:0] data
);
    logic [31:0] word;

    assign word = seed + {28'd0, beat};

    generate
        for (genvar gi = 0; gi < AXI_DWIDTH / 32; gi++) begin : g_copy
            assign data[gi*32 +: 32] = word;
        end
    endgenerate

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI3 burst master: writes a seeded pattern or reads and checks it,
// then pulses a status word with the worst response and sticky error flags.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int AXI_DWIDTH     = 64,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WRITE,
    input  logic [31:0]             CMD_ADDR,
    input  logic [3:0]              CMD_LEN,
    input  logic [ID_WIDTH-1:0]     CMD_ID,
    input  logic [31:0]             CMD_SEED,
    output logic [ID_WIDTH-1:0]     AWID,
    output logic [31:0]             AWADDR,
    output logic [3:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic [1:0]              AWLOCK,
    output logic [3:0]              AWCACHE,
    output logic [2:0]              AWPROT,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [ID_WIDTH-1:0]     WID,
    output logic [AXI_DWIDTH-1:0]   WDATA,
    output logic [AXI_DWIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [ID_WIDTH-1:0]     BID,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ID_WIDTH-1:0]     ARID,
    output logic [31:0]             ARADDR,
    output logic [3:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic [1:0]              ARLOCK,
    output logic [3:0]              ARCACHE,
    output logic [2:0]              ARPROT,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [ID_WIDTH-1:0]     RID,
    input  logic [AXI_DWIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY,
    output logic                    STS_VALID,
    output logic [1:0]              STS_RESP,
    output logic [3:0]              STS_ERR
);
    localparam int          STRB_W    = AXI_DWIDTH / 8;
    localparam logic [2:0]  AX_SIZE   = 3'($clog2(STRB_W));
    localparam logic [31:0] ADDR_MASK = ~(32'(STRB_W) - 32'd1);
    localparam int          TW        = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIM  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t              state_reg;
    logic [3:0]          len_reg, w_beat_reg, r_beat_reg;
    logic [ID_WIDTH-1:0] id_reg;
    logic [31:0]         seed_reg;
    logic                aw_done_reg, w_done_reg;
    logic [3:0]          err_reg;
    logic [1:0]          resp_reg;
    logic [TW-1:0]       timer_reg;

    assign AWLOCK  = 2'b00;
    assign AWCACHE = 4'b0000;
    assign AWPROT  = 3'b000;
    assign ARLOCK  = 2'b00;
    assign ARCACHE = 4'b0000;
    assign ARPROT  = 3'b000;

    logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, waiting, timeout_hit;
    assign accept  = (state_reg == ST_IDLE) && CMD_READY && CMD_VALID;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign b_hs    = BVALID && BREADY;
    assign ar_hs   = ARVALID && ARREADY;
    assign r_hs    = RVALID && RREADY;
    assign any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign waiting = (state_reg == ST_WR) || (state_reg == ST_WR_RESP) ||
                     (state_reg == ST_RD_ADDR) || (state_reg == ST_RD_DATA);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && waiting && !any_hs && (timer_reg >= TO_LIM);

    // In IDLE the generator prepares beat 0 of the incoming command; afterwards the next beat.
    logic [31:0]           gw_seed;
    logic [3:0]            gw_beat;
    logic [AXI_DWIDTH-1:0] gw_data, gr_data;
    assign gw_seed = (state_reg == ST_IDLE) ? CMD_SEED : seed_reg;
    assign gw_beat = (state_reg == ST_IDLE) ? 4'd0 : w_beat_reg + 4'd1;

    axi_burst_pattern_gen #(.AXI_DWIDTH(AXI_DWIDTH)) u_gen_w (
        .seed(gw_seed), .beat(gw_beat), .data(gw_data)
    );
    axi_burst_pattern_gen #(.AXI_DWIDTH(AXI_DWIDTH)) u_gen_r (
        .seed(seed_reg), .beat(r_beat_reg), .data(gr_data)
    );

    logic [3:0] r_err, b_err;
    logic [1:0] r_resp, b_resp;
    logic       r_end;
    always_comb begin
        r_err           = err_reg;
        r_err[ERR_DATA] = err_reg[ERR_DATA] | (RDATA != gr_data);
        r_err[ERR_ID]   = err_reg[ERR_ID]   | (RID != id_reg);
        r_err[ERR_LAST] = err_reg[ERR_LAST] | (RLAST != (r_beat_reg == len_reg));
        b_err           = err_reg;
        b_err[ERR_ID]   = err_reg[ERR_ID]   | (BID != id_reg);
        r_resp          = resp_worst(resp_reg, RRESP);
        b_resp          = resp_worst(resp_reg, BRESP);
        r_end           = RLAST || (r_beat_reg == len_reg);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg   <= ST_IDLE;
            CMD_READY   <= 1'b0;
            AWID <= '0; AWADDR <= '0; AWLEN <= '0; AWSIZE <= '0; AWBURST <= '0; AWVALID <= 1'b0;
            WID  <= '0; WDATA  <= '0; WSTRB <= '0; WLAST  <= 1'b0; WVALID  <= 1'b0;
            BREADY      <= 1'b0;
            ARID <= '0; ARADDR <= '0; ARLEN <= '0; ARSIZE <= '0; ARBURST <= '0; ARVALID <= 1'b0;
            RREADY      <= 1'b0;
            STS_VALID   <= 1'b0;
            STS_RESP    <= '0;
            STS_ERR     <= '0;
            len_reg     <= '0;
            w_beat_reg  <= '0;
            r_beat_reg  <= '0;
            id_reg      <= '0;
            seed_reg    <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            err_reg     <= '0;
            resp_reg    <= '0;
            timer_reg   <= '0;
        end else begin
            STS_VALID <= 1'b0;
            if (accept || any_hs)
                timer_reg <= TW'(1);
            else if (waiting)
                timer_reg <= timer_reg + 1'b1;

            if (timeout_hit) begin
                AWVALID              <= 1'b0;
                WVALID               <= 1'b0;
                BREADY               <= 1'b0;
                ARVALID              <= 1'b0;
                RREADY               <= 1'b0;
                err_reg[ERR_TIMEOUT] <= 1'b1;
                STS_VALID            <= 1'b1;
                STS_RESP             <= resp_reg;
                STS_ERR              <= err_reg | 4'b1000;
                state_reg            <= ST_DONE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (accept) begin
                            CMD_READY   <= 1'b0;
                            len_reg     <= CMD_LEN;
                            id_reg      <= CMD_ID;
                            seed_reg    <= CMD_SEED;
                            w_beat_reg  <= '0;
                            r_beat_reg  <= '0;
                            aw_done_reg <= 1'b0;
                            w_done_reg  <= 1'b0;
                            err_reg     <= '0;
                            resp_reg    <= RESP_OKAY;
                            if (CMD_WRITE) begin
                                AWID      <= CMD_ID;
                                AWADDR    <= CMD_ADDR & ADDR_MASK;
                                AWLEN     <= CMD_LEN;
                                AWSIZE    <= AX_SIZE;
                                AWBURST   <= BURST_INCR;
                                AWVALID   <= 1'b1;
                                WID       <= CMD_ID;
                                WDATA     <= gw_data;
                                WSTRB     <= '1;
                                WLAST     <= (CMD_LEN == 4'd0);
                                WVALID    <= 1'b1;
                                state_reg <= ST_WR;
                            end else begin
                                ARID      <= CMD_ID;
                                ARADDR    <= CMD_ADDR & ADDR_MASK;
                                ARLEN     <= CMD_LEN;
                                ARSIZE    <= AX_SIZE;
                                ARBURST   <= BURST_INCR;
                                ARVALID   <= 1'b1;
                                state_reg <= ST_RD_ADDR;
                            end
                        end else begin
                            CMD_READY <= 1'b1;
                        end
                    end
                    ST_WR: begin
                        if (aw_hs) begin
                            AWVALID     <= 1'b0;
                            aw_done_reg <= 1'b1;
                        end
                        if (w_hs) begin
                            if (WLAST) begin
                                WVALID     <= 1'b0;
                                WLAST      <= 1'b0;
                                w_done_reg <= 1'b1;
                            end else begin
                                w_beat_reg <= w_beat_reg + 4'd1;
                                WDATA      <= gw_data;
                                WLAST      <= (w_beat_reg + 4'd1 == len_reg);
                            end
                        end
                        if ((aw_done_reg || aw_hs) && (w_done_reg || (w_hs && WLAST))) begin
                            BREADY    <= 1'b1;
                            state_reg <= ST_WR_RESP;
                        end
                    end
                    ST_WR_RESP: begin
                        if (b_hs) begin
                            BREADY    <= 1'b0;
                            err_reg   <= b_err;
                            resp_reg  <= b_resp;
                            STS_VALID <= 1'b1;
                            STS_RESP  <= b_resp;
                            STS_ERR   <= b_err;
                            state_reg <= ST_DONE;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (ar_hs) begin
                            ARVALID   <= 1'b0;
                            RREADY    <= 1'b1;
                            state_reg <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (r_hs) begin
                            r_beat_reg <= r_beat_reg + 4'd1;
                            err_reg    <= r_err;
                            resp_reg   <= r_resp;
                            if (r_end) begin
                                RREADY    <= 1'b0;
                                STS_VALID <= 1'b1;
                                STS_RESP  <= r_resp;
                                STS_ERR   <= r_err;
                                state_reg <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        CMD_READY <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: the bench acts as the AXI slave and checks
// bus fields and the status word against hand-computed values.
module tb_axi_burst_master;
    import axi_burst_master_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
    logic [31:0] CMD_ADDR = '0, CMD_SEED = '0;
    logic [3:0]  CMD_LEN = '0, CMD_ID = '0;
    logic [3:0]  AWID, AWLEN, AWCACHE, WID, ARID, ARLEN, ARCACHE;
    logic [31:0] AWADDR, ARADDR;
    logic [2:0]  AWSIZE, AWPROT, ARSIZE, ARPROT;
    logic [1:0]  AWBURST, AWLOCK, ARBURST, ARLOCK;
    logic        AWVALID, AWREADY = 1'b1;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST, WVALID, WREADY = 1'b1;
    logic [3:0]  BID = '0;
    logic [1:0]  BRESP = '0;
    logic        BVALID = 1'b0, BREADY;
    logic        ARVALID, ARREADY = 1'b1;
    logic [3:0]  RID = '0;
    logic [63:0] RDATA = '0;
    logic [1:0]  RRESP = '0;
    logic        RLAST = 1'b0, RVALID = 1'b0, RREADY;
    logic        STS_VALID;
    logic [1:0]  STS_RESP;
    logic [3:0]  STS_ERR;

    int total = 0;
    int bad = 0;

    always #5 ACLK = ~ACLK;

    axi_burst_master #(.AXI_DWIDTH(64), .ID_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_ID(CMD_ID), .CMD_SEED(CMD_SEED),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .STS_VALID(STS_VALID), .STS_RESP(STS_RESP), .STS_ERR(STS_ERR)
    );

    // Issue one command starting from a falling edge; returns on the falling edge after accept.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                          input logic [3:0] id, input logic [31:0] seed);
        int g = 0;
        while (!CMD_READY && g < 20) begin
            @(negedge ACLK);
            g++;
        end
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_LEN = len; CMD_ID = id; CMD_SEED = seed;
        @(negedge ACLK);
        CMD_VALID = 1'b0;
    endtask

    // Slave R side: returns nbeats beats of pattern data (XOR mask), RLAST on beat last_at,
    // resp0 on beat 0. Returns on the falling edge after the final R handshake.
    task automatic r_beats(input int nbeats, input logic [31:0] seed, input int last_at,
                           input logic [3:0] id, input logic [1:0] resp0, input logic [63:0] mask);
        int k = 0;
        int g = 0;
        while (k < nbeats && g < 40) begin
            if (RREADY) begin
                RVALID = 1'b1;
                RID    = id;
                RDATA  = {2{seed + 32'(k)}} ^ mask;
                RLAST  = (k == last_at);
                RRESP  = (k == 0) ? resp0 : RESP_OKAY;
                k++;
            end else begin
                RVALID = 1'b0;
            end
            @(negedge ACLK);
            g++;
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] hs;
        repeat (2) @(negedge ACLK);
        hs = {CMD_READY, AWVALID, WVALID, BREADY, ARVALID, RREADY, STS_VALID};
        total++;
        if (hs !== 7'b0) begin
            bad++;
            $display("FAIL reset_handshake: got %b want 0000000", hs);
        end
        total++;
        if (AWADDR !== 32'h0 || ARADDR !== 32'h0 || WDATA !== 64'h0 || AWID !== 4'h0 ||
            STS_ERR !== 4'h0 || STS_RESP !== 2'b00) begin
            bad++;
            $display("FAIL reset_fields: awaddr=%h araddr=%h wdata=%h awid=%h err=%b resp=%b want all 0",
                     AWADDR, ARADDR, WDATA, AWID, STS_ERR, STS_RESP);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
        total++;
        if (CMD_READY !== 1'b1) begin
            bad++;
            $display("FAIL reset_cmd_ready: got %b want 1", CMD_READY);
        end
        $display("reset: cmd_ready=%b", CMD_READY);
    endtask

    task automatic test_write();
        int beats = 0;
        logic got = 1'b0;
        logic [63:0] exp;
        AWREADY = 1'b1; WREADY = 1'b1;
        do_cmd(1'b1, 32'h100, 4'd3, 4'h5, 32'h10);
        total++;
        if (AWVALID !== 1'b1 || AWADDR !== 32'h100 || AWLEN !== 4'd3 || AWSIZE !== 3'd3 ||
            AWBURST !== BURST_INCR || AWID !== 4'h5 || WVALID !== 1'b1) begin
            bad++;
            $display("FAIL wr_aw: valid=%b addr=%h len=%0d size=%0d burst=%b id=%h wvalid=%b want 1 100 3 3 01 5 1",
                     AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID, WVALID);
        end
        for (int g = 0; g < 30 && !got; g++) begin
            if (WVALID) begin
                exp = {2{32'h10 + 32'(beats)}};
                total++;
                if (WDATA !== exp || WLAST !== 1'(beats == 3) || WSTRB !== 8'hff || WID !== 4'h5) begin
                    bad++;
                    $display("FAIL wr_beat%0d: data=%h last=%b strb=%h wid=%h want %h %b ff 5",
                             beats, WDATA, WLAST, WSTRB, WID, exp, (beats == 3));
                end
                beats++;
            end
            if (BREADY) begin
                BVALID = 1'b1; BID = 4'h5; BRESP = RESP_OKAY;
            end
            @(negedge ACLK);
            if (BVALID) begin
                BVALID = 1'b0;
                got = 1'b1;
            end
        end
        total++;
        if (beats != 4 || STS_VALID !== 1'b1 || STS_RESP !== 2'b00 || STS_ERR !== 4'b0000) begin
            bad++;
            $display("FAIL wr_status: beats=%0d sts_valid=%b resp=%b err=%b want 4 1 00 0000",
                     beats, STS_VALID, STS_RESP, STS_ERR);
        end
        @(negedge ACLK);
        total++;
        if (STS_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
            bad++;
            $display("FAIL wr_pulse_idle: sts_valid=%b cmd_ready=%b want 0 1", STS_VALID, CMD_READY);
        end
        $display("write len=3 addr=100: beats=%0d resp=%b err=%b", beats, STS_RESP, STS_ERR);
    endtask

    task automatic test_read_data_err();
        ARREADY = 1'b1;
        do_cmd(1'b0, 32'h205, 4'd0, 4'h3, 32'h0);
        total++;
        if (ARVALID !== 1'b1 || ARADDR !== 32'h200 || ARLEN !== 4'd0 || ARID !== 4'h3 ||
            ARSIZE !== 3'd3 || ARBURST !== BURST_INCR) begin
            bad++;
            $display("FAIL rd_ar: valid=%b addr=%h len=%0d id=%h size=%0d burst=%b want 1 200 0 3 3 01",
                     ARVALID, ARADDR, ARLEN, ARID, ARSIZE, ARBURST);
        end
        r_beats(1, 32'h0, 0, 4'h3, RESP_OKAY, 64'haaaa5555aaaa5555);
        total++;
        if (STS_VALID !== 1'b1 || STS_ERR !== 4'b0001 || STS_RESP !== 2'b00) begin
            bad++;
            $display("FAIL rd_data_err: sts_valid=%b err=%b resp=%b want 1 0001 00", STS_VALID, STS_ERR, STS_RESP);
        end
        $display("read len=0 bad data: err=%b", STS_ERR);
        @(negedge ACLK);
    endtask

    task automatic test_read_resp();
        do_cmd(1'b0, 32'h300, 4'd1, 4'h9, 32'h20);
        r_beats(2, 32'h20, 1, 4'h9, RESP_SLVERR, 64'h0);
        total++;
        if (STS_VALID !== 1'b1 || STS_ERR !== 4'b0000 || STS_RESP !== RESP_SLVERR) begin
            bad++;
            $display("FAIL rd_resp: sts_valid=%b err=%b resp=%b want 1 0000 10", STS_VALID, STS_ERR, STS_RESP);
        end
        $display("read len=1 slverr beat0: err=%b resp=%b", STS_ERR, STS_RESP);
        @(negedge ACLK);
    endtask

    task automatic test_read_id();
        do_cmd(1'b0, 32'h380, 4'd0, 4'h9, 32'h30);
        r_beats(1, 32'h30, 0, 4'hA, RESP_DECERR, 64'h0);
        total++;
        if (STS_VALID !== 1'b1 || STS_ERR !== 4'b0100 || STS_RESP !== RESP_DECERR) begin
            bad++;
            $display("FAIL rd_id: sts_valid=%b err=%b resp=%b want 1 0100 11", STS_VALID, STS_ERR, STS_RESP);
        end
        $display("read wrong rid: err=%b resp=%b", STS_ERR, STS_RESP);
        @(negedge ACLK);
    endtask

    task automatic test_early_rlast();
        do_cmd(1'b0, 32'h400, 4'd3, 4'h2, 32'h40);
        r_beats(2, 32'h40, 1, 4'h2, RESP_OKAY, 64'h0);
        total++;
        if (STS_VALID !== 1'b1 || STS_ERR !== 4'b0010 || RREADY !== 1'b0) begin
            bad++;
            $display("FAIL rd_early_last: sts_valid=%b err=%b rready=%b want 1 0010 0", STS_VALID, STS_ERR, RREADY);
        end
        @(negedge ACLK);
        total++;
        if (CMD_READY !== 1'b1) begin
            bad++;
            $display("FAIL rd_early_idle: cmd_ready=%b want 1", CMD_READY);
        end
        $display("read early rlast: err=%b", STS_ERR);
    endtask

    task automatic test_aw_stall();
        int wbeats = 0;
        AWREADY = 1'b0; WREADY = 1'b1;
        do_cmd(1'b1, 32'h340, 4'd2, 4'h6, 32'h80);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (AWVALID !== 1'b1 || AWADDR !== 32'h340 || AWLEN !== 4'd2 || BREADY !== 1'b0) begin
                bad++;
                $display("FAIL stall_aw_hold%0d: awvalid=%b awaddr=%h awlen=%0d bready=%b want 1 340 2 0",
                         i, AWVALID, AWADDR, AWLEN, BREADY);
            end
            if (WVALID) wbeats++;
            if (i == 4) AWREADY = 1'b1;
            @(negedge ACLK);
        end
        AWREADY = 1'b1;
        total++;
        if (wbeats != 3 || WVALID !== 1'b0 || AWVALID !== 1'b0 || BREADY !== 1'b1) begin
            bad++;
            $display("FAIL stall_bready: wbeats=%0d wvalid=%b awvalid=%b bready=%b want 3 0 0 1",
                     wbeats, WVALID, AWVALID, BREADY);
        end
        BVALID = 1'b1; BID = 4'h7; BRESP = RESP_SLVERR;
        @(negedge ACLK);
        BVALID = 1'b0;
        total++;
        if (STS_VALID !== 1'b1 || STS_RESP !== RESP_SLVERR || STS_ERR !== 4'b0100) begin
            bad++;
            $display("FAIL stall_status: sts_valid=%b resp=%b err=%b want 1 10 0100", STS_VALID, STS_RESP, STS_ERR);
        end
        $display("write aw stall: wbeats=%0d resp=%b err=%b", wbeats, STS_RESP, STS_ERR);
        @(negedge ACLK);
    endtask

    task automatic test_timeout();
        int n = 0;
        AWREADY = 1'b1; WREADY = 1'b1;
        do_cmd(1'b1, 32'h500, 4'd0, 4'h1, 32'h90);
        while (!STS_VALID && n < 40) begin
            @(negedge ACLK);
            n++;
        end
        total++;
        if (n != 16 || STS_ERR !== 4'b1000 || STS_RESP !== 2'b00 || BREADY !== 1'b0) begin
            bad++;
            $display("FAIL timeout: cycles=%0d err=%b resp=%b bready=%b want 16 1000 00 0", n, STS_ERR, STS_RESP, BREADY);
        end
        $display("write no bvalid: timeout after %0d cycles err=%b", n, STS_ERR);
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid();
        int g = 0;
        logic seen = 1'b0;
        logic [6:0] hs;
        do_cmd(1'b0, 32'h600, 4'd3, 4'h4, 32'h60);
        while (!RREADY && g < 20) begin
            @(negedge ACLK);
            g++;
        end
        for (int k = 0; k < 3; k++) begin
            RVALID = 1'b1; RID = 4'h4; RDATA = {2{32'h60 + 32'(k)}}; RLAST = 1'b0; RRESP = RESP_OKAY;
            if (k == 2) begin
                #2;
                ARESETN = 1'b0;
            end
            @(negedge ACLK);
        end
        RVALID = 1'b0;
        hs = {CMD_READY, AWVALID, WVALID, BREADY, ARVALID, RREADY, STS_VALID};
        total++;
        if (hs !== 7'b0 || ARADDR !== 32'h0 || ARID !== 4'h0 || STS_ERR !== 4'h0) begin
            bad++;
            $display("FAIL mid_reset: hs=%b araddr=%h arid=%h err=%b want 0000000 0 0 0", hs, ARADDR, ARID, STS_ERR);
        end
        ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (STS_VALID) seen = 1'b1;
            @(negedge ACLK);
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_sts: sts_valid seen=%b want 0", seen);
        end
        $display("reset during read beat 2: outputs cleared, sts seen=%b", seen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_data_err();
        test_read_resp();
        test_read_id();
        test_early_rlast();
        test_aw_stall();
        test_timeout();
        test_reset_mid();
        test_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
